mc_scoreboard: RTL and testbench
================================

Name: mc_scoreboard

Overview:
- Producer of the multicycle stall/hazard signals `multicycle_hazard` and `rd_busy`, which the pipeline controller consumes.
- Tracks in-flight multicycle operations: integer divide (unit 0) and FP div/sqrt (unit 1).
- Holds a 64-entry destination busy vector: 32 integer + 32 FP registers.
- Sequences each unit through issue → countdown → writeback request → ack.
- Sits beside the EXE stage. Source-register compares are done against the ID stage.

Parameters:
- `DIV_LAT`, 33, cycles from issue to result for unit 0 (≥2).
- `FDIV_LAT`, 20, cycles from issue to result for unit 1 (≥2).
- `CNT_W`, 6, countdown counter width; must satisfy 2^`CNT_W` > max(`DIV_LAT`, `FDIV_LAT`).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall_pipl`  in  1  global pipeline stall; blocks issue.
- `exe_mc_valid`  in  1  EXE holds a multicycle op.
- `exe_mc_unit`  in  1  0 = int div, 1 = FP div/sqrt.
- `exe_rd`  in  5  destination of the EXE op.
- `exe_rd_fp`  in  1  destination is in the FP file.
- `id_rs1`, `id_rs2`, `id_rs3`  in  5 each  ID-stage sources.
- `id_rs1_fp`, `id_rs2_fp`, `id_rs3_fp`  in  1 each  per-source file select.
- `id_rs1_use`, `id_rs2_use`, `id_rs3_use`  in  1 each  source is actually read.
- `id_rd`, `id_rd_fp`, `id_rd_use`  in  5/1/1  ID destination, for WAW.
- `mc_wb_ack`  in  2  writeback port granted, per unit.
- `mc_issue`  out  2  one-cycle start pulse to the unit.
- `mc_wb_valid`  out  2  result ready, per unit.
- `mc_wb_rd`  out  5x2  tagged destination, per unit.
- `mc_wb_rd_fp`  out  2  tagged file select, per unit.
- `multicycle_hazard`  out  1  EXE op cannot issue this cycle.
- `rd_busy`  out  1  ID op has a RAW/WAW hit on a busy register.

Behaviour:
- Per-unit FSM with states IDLE, BUSY, WB.
  - IDLE→BUSY on issue: load cnt = LAT−1, latch rd/fp tag, set busy bit {fp,rd}.
  - BUSY: decrement cnt; go to WB when cnt==0 (result available LAT cycles after the issue edge).
  - WB: hold `mc_wb_valid`=1 with stable tag until `mc_wb_ack`. On ack, clear the busy bit and go to IDLE.
- Issue condition: `exe_mc_valid` & !`stall_pipl` & target unit IDLE. `mc_issue[u]` pulses in that same cycle.
- `multicycle_hazard` = `exe_mc_valid` & target unit not IDLE. Combinational.
  - Same-cycle ack and new request to the same unit: hazard stays 1; issue happens the following cycle.
- Busy vector: index = {fp,rd}.
  - Integer x0 (fp=0, rd=0) is never set.
  - If set and clear hit the same index in the same cycle, set wins.
- `rd_busy`: OR over the three sources and the destination of (use & busy[{fp,reg}]).
  - Integer x0 is excluded.
  - Combinational from registered busy state, so there is no bypass: the busy bit clears the cycle after the ack.
- An op issued while `rd_busy` is high is impossible; the controller stalls ID. Not checked in this block.
- Both units may be in WB at once; acks are independent.
- Flushes do not affect this block: the multicycle op in EXE is older than any branch it can be flushed by.
- Reset (synchronous): all FSMs IDLE, counters 0, busy vector 0.
  - All outputs 0 one cycle after `rst` is seen high.
  - Reset mid-operation abandons in-flight ops silently; no writeback request is made.

Optional Feature:
- Macro: `MC_SCOREBOARD_PERF_EN`.
- Defined: adds 32-bit saturating counters `perf_mc_hazard_cyc` and `perf_rd_busy_cyc` as extra outputs. Each increments every cycle its signal is 1. Both reset to 0.
- Undefined: ports and logic are absent. Functional behaviour is identical.

Decomposition:
- Package `mc_sb_pkg` holds:
  - FSM state enum `mc_state_t` {IDLE, BUSY, WB};
  - unit index constants `MC_UNIT_DIV`=0, `MC_UNIT_FDIV`=1;
  - struct `mc_tag_t` {fp, rd}.
- Sub-module `mc_unit_tracker`: one FSM plus counter plus tag, latency as parameter, instantiated twice.
- Busy vector and hazard compare stay in the top module.

Test Plan:
- Issue div, rd=x5, at t0 with `DIV_LAT`=33:
  - `mc_issue[0]`=1 at t0;
  - `mc_wb_valid[0]`=1 from t33 with `mc_wb_rd`=5;
  - ack at t35 → `busy[5]` cleared at t36.
- While div rd=x5 is BUSY, ID reads rs2=x5 → `rd_busy`=1. ID reads f5 (fp=1) → `rd_busy`=0. ID reads x0 with an int op to x0 → `rd_busy`=0.
- Back-to-back: second div presented while unit 0 is BUSY → `multicycle_hazard`=1 until the cycle after the ack, then `mc_issue[0]` pulses. A concurrent fdiv presented at the same time issues immediately.
- `stall_pipl`=1 with a valid div and idle unit → no issue, busy vector unchanged. Issue occurs in the first cycle `stall_pipl`=0.
- Both units reach WB together; ack unit 1 first, then unit 0 → each busy bit clears independently and the tags stay stable while waiting.
- Assert `rst` mid-BUSY at cycle 10 → next cycle all outputs 0. A new div issued afterwards completes normally at full latency.

Source files
------------

// File: rtl/mc_sb_pkg.sv
// Shared types and helpers for the multicycle scoreboard.
//   mc_state_t : per-unit tracker FSM state (IDLE, BUSY, WB)
//   mc_tag_t   : destination tag {fp, rd}; its packed value is the busy-vector index
//   MC_UNIT_*  : unit index constants (0 = integer divide, 1 = FP div/sqrt)
package mc_sb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    WB   = 2'b10
  } mc_state_t;

  localparam logic MC_UNIT_DIV  = 1'b0;
  localparam logic MC_UNIT_FDIV = 1'b1;

  typedef struct packed {
    logic       fp;
    logic [4:0] rd;
  } mc_tag_t;

  // Busy-vector index: FP registers occupy the upper 32 entries.
  function automatic logic [5:0] tag_idx(input mc_tag_t tag);
    return {tag.fp, tag.rd};
  endfunction

  // One register reference against the busy vector; integer x0 never hits.
  function automatic logic reg_hit(input logic       use_reg,
                                   input logic       fp,
                                   input logic [4:0] r,
                                   input logic [63:0] busy);
    return use_reg & (fp | (r != 5'd0)) & busy[{fp, r}];
  endfunction

endpackage

// File: rtl/mc_unit_tracker.sv
// Tracks one multicycle unit: issue -> countdown -> writeback request -> ack.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   issue_i     : start pulse (only honoured in IDLE)
//   tag_i       : destination tag latched on issue
//   ack_i       : writeback port granted (only honoured in WB)
//   idle_o      : unit can accept a new op
//   wb_valid_o  : result ready, held until ack
//   tag_o       : latched destination tag, stable while waiting in WB
//   clear_o     : ack accepted this cycle; release the destination busy bit
module mc_unit_tracker
  import mc_sb_pkg::*;
#(
  parameter int unsigned Lat  = 33,
  parameter int unsigned CntW = 6
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    issue_i,
  input  mc_tag_t tag_i,
  input  logic    ack_i,
  output logic    idle_o,
  output logic    wb_valid_o,
  output mc_tag_t tag_o,
  output logic    clear_o
);

  mc_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mc_tag_t         tag_q, tag_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    clear_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue_i) begin
          state_d = BUSY;
          cnt_d   = CntW'(Lat - 1);
          tag_d   = tag_i;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        // The count reaches zero as WB is entered, so the result is
        // presented exactly Lat cycles after the issue cycle.
        if (cnt_q == CntW'(1)) begin
          state_d = WB;
        end
      end
      WB: begin
        if (ack_i) begin
          state_d = IDLE;
          clear_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  assign idle_o     = (state_q == IDLE);
  assign wb_valid_o = (state_q == WB);
  assign tag_o      = tag_q;

endmodule

// File: rtl/mc_scoreboard.sv
// Multicycle scoreboard: tracks the integer divider (unit 0) and FP div/sqrt
// (unit 1), keeps a 64-entry destination busy vector (32 int + 32 FP) and
// produces the pipeline stall signals.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall_pipl               : global stall, blocks issue
//   exe_mc_valid/unit/rd/rd_fp : multicycle op held in EXE
//   id_rs{1,2,3}[_fp,_use]   : ID-stage sources for RAW checks
//   id_rd[_fp,_use]          : ID-stage destination for WAW checks
//   mc_wb_ack                : per-unit writeback grant
//   mc_issue                 : per-unit one-cycle start pulse
//   mc_wb_valid/rd/rd_fp     : per-unit writeback request and tag
//   multicycle_hazard        : EXE op cannot issue this cycle
//   rd_busy                  : ID op hits a busy register
// Optional: define MC_SCOREBOARD_PERF_EN to add saturating cycle counters
//   perf_mc_hazard_cyc and perf_rd_busy_cyc.
module mc_scoreboard
  import mc_sb_pkg::*;
#(
  parameter int unsigned DIV_LAT  = 33,
  parameter int unsigned FDIV_LAT = 20,
  parameter int unsigned CNT_W    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_pipl,
  input  logic            exe_mc_valid,
  input  logic            exe_mc_unit,
  input  logic [4:0]      exe_rd,
  input  logic            exe_rd_fp,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rs3,
  input  logic            id_rs1_fp,
  input  logic            id_rs2_fp,
  input  logic            id_rs3_fp,
  input  logic            id_rs1_use,
  input  logic            id_rs2_use,
  input  logic            id_rs3_use,
  input  logic [4:0]      id_rd,
  input  logic            id_rd_fp,
  input  logic            id_rd_use,
  input  logic [1:0]      mc_wb_ack,
  output logic [1:0]      mc_issue,
  output logic [1:0]      mc_wb_valid,
  output logic [1:0][4:0] mc_wb_rd,
  output logic [1:0]      mc_wb_rd_fp,
  output logic            multicycle_hazard,
  output logic            rd_busy
`ifdef MC_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]     perf_mc_hazard_cyc,
  output logic [31:0]     perf_rd_busy_cyc
`endif
);

  logic [1:0] unit_idle;
  logic [1:0] unit_clear;
  mc_tag_t    unit_tag [2];
  mc_tag_t    exe_tag;
  logic       tgt_idle;
  logic       issue_ok;
  logic [63:0] busy_q, busy_d;

  assign exe_tag  = '{fp: exe_rd_fp, rd: exe_rd};
  assign tgt_idle = unit_idle[exe_mc_unit];
  // Reset also gates issue so nothing starts while reset is asserted.
  assign issue_ok = exe_mc_valid & ~stall_pipl & tgt_idle & ~rst;

  always_comb begin
    mc_issue[0] = issue_ok & (exe_mc_unit == MC_UNIT_DIV);
    mc_issue[1] = issue_ok & (exe_mc_unit == MC_UNIT_FDIV);
  end

  assign multicycle_hazard = exe_mc_valid & ~tgt_idle;

  for (genvar u = 0; u < 2; u++) begin : g_unit
    mc_unit_tracker #(
      .Lat  (u == 0 ? DIV_LAT : FDIV_LAT),
      .CntW (CNT_W)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .issue_i    (mc_issue[u]),
      .tag_i      (exe_tag),
      .ack_i      (mc_wb_ack[u]),
      .idle_o     (unit_idle[u]),
      .wb_valid_o (mc_wb_valid[u]),
      .tag_o      (unit_tag[u]),
      .clear_o    (unit_clear[u])
    );
    assign mc_wb_rd[u]    = unit_tag[u].rd;
    assign mc_wb_rd_fp[u] = unit_tag[u].fp;
  end

  // Clears first, then the set, so a same-cycle set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    for (int u = 0; u < 2; u++) begin
      if (unit_clear[u]) begin
        busy_d[tag_idx(unit_tag[u])] = 1'b0;
      end
    end
    if (issue_ok && (tag_idx(exe_tag) != 6'd0)) begin
      busy_d[tag_idx(exe_tag)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Registered state only: a busy bit is still seen in the ack cycle.
  assign rd_busy = reg_hit(id_rs1_use, id_rs1_fp, id_rs1, busy_q)
                 | reg_hit(id_rs2_use, id_rs2_fp, id_rs2, busy_q)
                 | reg_hit(id_rs3_use, id_rs3_fp, id_rs3, busy_q)
                 | reg_hit(id_rd_use,  id_rd_fp,  id_rd,  busy_q);

`ifdef MC_SCOREBOARD_PERF_EN
  logic [31:0] perf_haz_q, perf_haz_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_haz_d  = perf_haz_q;
    perf_busy_d = perf_busy_q;
    if (multicycle_hazard && (perf_haz_q != '1)) begin
      perf_haz_d = perf_haz_q + 32'd1;
    end
    if (rd_busy && (perf_busy_q != '1)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_haz_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_haz_q  <= perf_haz_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_mc_hazard_cyc = perf_haz_q;
  assign perf_rd_busy_cyc   = perf_busy_q;
`endif

endmodule

// File: tb/tb_mc_scoreboard.sv
module tb_mc_scoreboard;

  logic            clk;
  logic            rst;
  logic            stall_pipl;
  logic            exe_mc_valid;
  logic            exe_mc_unit;
  logic [4:0]      exe_rd;
  logic            exe_rd_fp;
  logic [4:0]      id_rs1, id_rs2, id_rs3;
  logic            id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic            id_rs1_use, id_rs2_use, id_rs3_use;
  logic [4:0]      id_rd;
  logic            id_rd_fp;
  logic            id_rd_use;
  logic [1:0]      mc_wb_ack;
  logic [1:0]      mc_issue;
  logic [1:0]      mc_wb_valid;
  logic [1:0][4:0] mc_wb_rd;
  logic [1:0]      mc_wb_rd_fp;
  logic            multicycle_hazard;
  logic            rd_busy;

  int n_cmp = 0;
  int n_err = 0;

  mc_scoreboard #(
    .DIV_LAT  (33),
    .FDIV_LAT (20),
    .CNT_W    (6)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_pipl        (stall_pipl),
    .exe_mc_valid      (exe_mc_valid),
    .exe_mc_unit       (exe_mc_unit),
    .exe_rd            (exe_rd),
    .exe_rd_fp         (exe_rd_fp),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rs3            (id_rs3),
    .id_rs1_fp         (id_rs1_fp),
    .id_rs2_fp         (id_rs2_fp),
    .id_rs3_fp         (id_rs3_fp),
    .id_rs1_use        (id_rs1_use),
    .id_rs2_use        (id_rs2_use),
    .id_rs3_use        (id_rs3_use),
    .id_rd             (id_rd),
    .id_rd_fp          (id_rd_fp),
    .id_rd_use         (id_rd_use),
    .mc_wb_ack         (mc_wb_ack),
    .mc_issue          (mc_issue),
    .mc_wb_valid       (mc_wb_valid),
    .mc_wb_rd          (mc_wb_rd),
    .mc_wb_rd_fp       (mc_wb_rd_fp),
    .multicycle_hazard (multicycle_hazard),
    .rd_busy           (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_pipl   = 1'b0;
    exe_mc_valid = 1'b0;
    exe_mc_unit  = 1'b0;
    exe_rd       = 5'd0;
    exe_rd_fp    = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs3 = 5'd0;
    id_rs1_fp = 1'b0; id_rs2_fp = 1'b0; id_rs3_fp = 1'b0;
    id_rs1_use = 1'b0; id_rs2_use = 1'b0; id_rs3_use = 1'b0;
    id_rd = 5'd0; id_rd_fp = 1'b0; id_rd_use = 1'b0;
    mc_wb_ack = 2'b00;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic drive_exe(input logic unit, input logic [4:0] rd, input logic fp);
    exe_mc_valid = 1'b1;
    exe_mc_unit  = unit;
    exe_rd       = rd;
    exe_rd_fp    = fp;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    nxt();
    #1;
    n_cmp++;
    if ((mc_issue !== 2'b00) || (mc_wb_valid !== 2'b00)) begin
      n_err++;
      $display("FAIL reset_ctrl: issue=%b wb_valid=%b expected 00/00", mc_issue, mc_wb_valid);
    end
    n_cmp++;
    if ((mc_wb_rd !== 10'd0) || (mc_wb_rd_fp !== 2'b00)) begin
      n_err++;
      $display("FAIL reset_tag: wb_rd=%h wb_rd_fp=%b expected 0/00", mc_wb_rd, mc_wb_rd_fp);
    end
    n_cmp++;
    if ((multicycle_hazard !== 1'b0) || (rd_busy !== 1'b0)) begin
      n_err++;
      $display("FAIL reset_stall: hazard=%b rd_busy=%b expected 0/0", multicycle_hazard, rd_busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_div_issue();
    bit early;
    apply_reset();
    drive_exe(1'b0, 5'd5, 1'b0);                    // t0
    #1;
    n_cmp++;
    if ((mc_issue !== 2'b01) || (multicycle_hazard !== 1'b0)) begin
      n_err++;
      $display("FAIL div_issue: issue=%b hazard=%b expected 01/0", mc_issue, multicycle_hazard);
    end
    nxt();                                          // t1
    exe_mc_valid = 1'b0;
    id_rs2 = 5'd5; id_rs2_use = 1'b1;
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b1) || (mc_issue !== 2'b00)) begin
      n_err++;
      $display("FAIL raw_x5: rd_busy=%b issue=%b expected 1/00", rd_busy, mc_issue);
    end
    id_rs2_fp = 1'b1;
    #1;
    n_cmp++;
    if (rd_busy !== 1'b0) begin
      n_err++;
      $display("FAIL fp_f5_free: rd_busy=%b expected 0", rd_busy);
    end
    id_rs2_use = 1'b0; id_rs2_fp = 1'b0;
    id_rs1 = 5'd0; id_rs1_use = 1'b1; id_rd = 5'd0; id_rd_use = 1'b1;
    #1;
    n_cmp++;
    if (rd_busy !== 1'b0) begin
      n_err++;
      $display("FAIL x0_excluded: rd_busy=%b expected 0", rd_busy);
    end
    clear_inputs();
    early = 1'b0;
    for (int t = 2; t <= 33; t++) begin
      nxt();
      if ((t < 33) && (mc_wb_valid[0] === 1'b1)) early = 1'b1;
    end                                             // now t33
    n_cmp++;
    if ((early !== 1'b0) || (mc_wb_valid !== 2'b01)) begin
      n_err++;
      $display("FAIL div_latency: early=%b wb_valid@t33=%b expected 0/01", early, mc_wb_valid);
    end
    n_cmp++;
    if ((mc_wb_rd[0] !== 5'd5) || (mc_wb_rd_fp[0] !== 1'b0)) begin
      n_err++;
      $display("FAIL div_tag: rd=%0d fp=%b expected 5/0", mc_wb_rd[0], mc_wb_rd_fp[0]);
    end
    nxt();                                          // t34
    nxt();                                          // t35
    mc_wb_ack = 2'b01;
    id_rs1 = 5'd5; id_rs1_use = 1'b1;
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b1) || (mc_wb_valid !== 2'b01) || (mc_wb_rd[0] !== 5'd5)) begin
      n_err++;
      $display("FAIL busy_in_ack_cycle: rd_busy=%b wb_valid=%b rd=%0d expected 1/01/5",
               rd_busy, mc_wb_valid, mc_wb_rd[0]);
    end
    nxt();                                          // t36
    mc_wb_ack = 2'b00;
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b0) || (mc_wb_valid !== 2'b00)) begin
      n_err++;
      $display("FAIL busy_cleared: rd_busy=%b wb_valid=%b expected 0/00", rd_busy, mc_wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit bad;
    apply_reset();
    drive_exe(1'b0, 5'd7, 1'b0);                    // t0: div x7
    nxt();                                          // t1: fdiv f3
    drive_exe(1'b1, 5'd3, 1'b1);
    #1;
    n_cmp++;
    if ((mc_issue !== 2'b10) || (multicycle_hazard !== 1'b0)) begin
      n_err++;
      $display("FAIL fdiv_concurrent: issue=%b hazard=%b expected 10/0", mc_issue, multicycle_hazard);
    end
    nxt();                                          // t2: second div x8 waits
    drive_exe(1'b0, 5'd8, 1'b0);
    #1;
    bad = (multicycle_hazard !== 1'b1) || (mc_issue !== 2'b00);
    for (int t = 3; t <= 33; t++) begin
      nxt();
      mc_wb_ack = 2'b00;
      if (t == 21) begin
        mc_wb_ack = 2'b10;
        n_cmp++;
        if ((mc_wb_valid[1] !== 1'b1) || (mc_wb_rd[1] !== 5'd3) || (mc_wb_rd_fp[1] !== 1'b1)) begin
          n_err++;
          $display("FAIL fdiv_wb: valid=%b rd=%0d fp=%b expected 1/3/1",
                   mc_wb_valid[1], mc_wb_rd[1], mc_wb_rd_fp[1]);
        end
      end
      if (t == 33) begin
        mc_wb_ack = 2'b01;
        n_cmp++;
        if ((mc_wb_valid[0] !== 1'b1) || (mc_wb_rd[0] !== 5'd7)) begin
          n_err++;
          $display("FAIL b2b_div_wb: valid=%b rd=%0d expected 1/7", mc_wb_valid[0], mc_wb_rd[0]);
        end
      end
      #1;
      if ((multicycle_hazard !== 1'b1) || (mc_issue !== 2'b00)) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_hazard_held: got a cycle without hazard/with issue, expected none");
    end
    nxt();                                          // t34
    mc_wb_ack = 2'b00;
    #1;
    n_cmp++;
    if ((multicycle_hazard !== 1'b0) || (mc_issue !== 2'b01)) begin
      n_err++;
      $display("FAIL b2b_issue_after_ack: hazard=%b issue=%b expected 0/01",
               multicycle_hazard, mc_issue);
    end
    nxt();                                          // t35
    exe_mc_valid = 1'b0;
    id_rs1 = 5'd8; id_rs1_use = 1'b1;
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b1) || (mc_issue !== 2'b00)) begin
      n_err++;
      $display("FAIL b2b_x8_busy: rd_busy=%b issue=%b expected 1/00", rd_busy, mc_issue);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    stall_pipl = 1'b1;
    drive_exe(1'b0, 5'd9, 1'b0);
    id_rs1 = 5'd9; id_rs1_use = 1'b1;
    #1;
    n_cmp++;
    if ((mc_issue !== 2'b00) || (multicycle_hazard !== 1'b0)) begin
      n_err++;
      $display("FAIL stall_no_issue: issue=%b hazard=%b expected 00/0", mc_issue, multicycle_hazard);
    end
    nxt();
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b0) || (mc_issue !== 2'b00)) begin
      n_err++;
      $display("FAIL stall_busy_unchanged: rd_busy=%b issue=%b expected 0/00", rd_busy, mc_issue);
    end
    stall_pipl = 1'b0;
    #1;
    n_cmp++;
    if (mc_issue !== 2'b01) begin
      n_err++;
      $display("FAIL stall_release_issue: issue=%b expected 01", mc_issue);
    end
    nxt();
    exe_mc_valid = 1'b0;
    #1;
    n_cmp++;
    if (rd_busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_then_busy: rd_busy=%b expected 1", rd_busy);
    end
  endtask

  task automatic test_both_wb();
    apply_reset();
    drive_exe(1'b0, 5'd10, 1'b0);                   // t0: div x10
    nxt();
    exe_mc_valid = 1'b0;
    for (int t = 2; t <= 13; t++) nxt();            // t13
    drive_exe(1'b1, 5'd10, 1'b1);                   // fdiv f10
    #1;
    n_cmp++;
    if (mc_issue !== 2'b10) begin
      n_err++;
      $display("FAIL both_fdiv_issue: issue=%b expected 10", mc_issue);
    end
    nxt();
    exe_mc_valid = 1'b0;
    for (int t = 15; t <= 33; t++) nxt();           // t33
    n_cmp++;
    if ((mc_wb_valid !== 2'b11) || (mc_wb_rd !== {5'd10, 5'd10}) || (mc_wb_rd_fp !== 2'b10)) begin
      n_err++;
      $display("FAIL both_wb: valid=%b rd=%h fp=%b expected 11/14a/10",
               mc_wb_valid, mc_wb_rd, mc_wb_rd_fp);
    end
    nxt();
    nxt();
    nxt();                                          // t36
    n_cmp++;
    if ((mc_wb_valid !== 2'b11) || (mc_wb_rd !== {5'd10, 5'd10}) || (mc_wb_rd_fp !== 2'b10)) begin
      n_err++;
      $display("FAIL both_tag_stable: valid=%b rd=%h fp=%b expected 11/14a/10",
               mc_wb_valid, mc_wb_rd, mc_wb_rd_fp);
    end
    mc_wb_ack = 2'b10;
    nxt();                                          // t37
    mc_wb_ack = 2'b00;
    id_rs1 = 5'd10; id_rs1_fp = 1'b1; id_rs1_use = 1'b1;
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b0) || (mc_wb_valid !== 2'b01) || (mc_wb_rd[0] !== 5'd10)) begin
      n_err++;
      $display("FAIL ack1_first: rd_busy(f10)=%b valid=%b rd0=%0d expected 0/01/10",
               rd_busy, mc_wb_valid, mc_wb_rd[0]);
    end
    id_rs1_fp = 1'b0;
    #1;
    n_cmp++;
    if (rd_busy !== 1'b1) begin
      n_err++;
      $display("FAIL x10_still_busy: rd_busy=%b expected 1", rd_busy);
    end
    mc_wb_ack = 2'b01;
    nxt();                                          // t38
    mc_wb_ack = 2'b00;
    #1;
    n_cmp++;
    if ((rd_busy !== 1'b0) || (mc_wb_valid !== 2'b00)) begin
      n_err++;
      $display("FAIL ack0_second: rd_busy(x10)=%b valid=%b expected 0/00", rd_busy, mc_wb_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit early;
    apply_reset();
    drive_exe(1'b0, 5'd6, 1'b0);                    // t0
    nxt();
    exe_mc_valid = 1'b0;
    for (int t = 2; t <= 10; t++) nxt();            // t10
    rst = 1'b1;
    nxt();                                          // t11
    rst = 1'b0;
    id_rs1 = 5'd6; id_rs1_use = 1'b1;
    #1;
    n_cmp++;
    if ((mc_wb_valid !== 2'b00) || (mc_issue !== 2'b00) || (multicycle_hazard !== 1'b0) ||
        (rd_busy !== 1'b0) || (mc_wb_rd !== 10'd0) || (mc_wb_rd_fp !== 2'b00)) begin
      n_err++;
      $display("FAIL reset_mid_outputs: valid=%b issue=%b haz=%b busy=%b rd=%h fp=%b expected all 0",
               mc_wb_valid, mc_issue, multicycle_hazard, rd_busy, mc_wb_rd, mc_wb_rd_fp);
    end
    id_rs1_use = 1'b0;
    drive_exe(1'b0, 5'd6, 1'b0);                    // new t0
    #1;
    n_cmp++;
    if (mc_issue !== 2'b01) begin
      n_err++;
      $display("FAIL reset_mid_reissue: issue=%b expected 01", mc_issue);
    end
    nxt();
    exe_mc_valid = 1'b0;
    early = (mc_wb_valid !== 2'b00);
    for (int t = 2; t <= 33; t++) begin
      nxt();
      if ((t < 33) && (mc_wb_valid !== 2'b00)) early = 1'b1;
    end
    n_cmp++;
    if ((early !== 1'b0) || (mc_wb_valid !== 2'b01) || (mc_wb_rd[0] !== 5'd6)) begin
      n_err++;
      $display("FAIL reset_mid_full_latency: early=%b valid=%b rd=%0d expected 0/01/6",
               early, mc_wb_valid, mc_wb_rd[0]);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_div_issue();
    test_back_to_back();
    test_stall();
    test_both_wb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
